div_unit: RTL and testbench

Multi-cycle 32-bit integer divider with its own sequencing FSM, serving the MIPS DIV/DIVU instructions in the EX stage. EX raises a request with the operands. The block runs a 32-iteration restoring shift-subtract, fixes signs, and returns quotient/remainder for the HI/LO write path. EX stalls on `start & ~done`. A pipeline flush (exception or eret) aborts the operation in flight.

---
 rtl/div_unit_pkg.sv | 15 +
 rtl/div_datapath.sv | 33 +++
 rtl/div_unit.sv | 123 ++++++++++++
 tb/tb_div_unit.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider: FSM state encodings and sizing constants.
package div_unit_pkg;

    typedef enum logic [2:0] {
        DivIdle = 3'd0,
        DivPrep = 3'd1,
        DivCalc = 3'd2,
        DivFix  = 3'd3,
        DivDone = 3'd4
    } div_state_e;

    localparam int unsigned DivCycles = 32;
    localparam int unsigned DivCntW   = 6;

endpackage

// File: rtl/div_datapath.sv
// Restoring shift-subtract core: {rem,quo} shift register plus a WIDTH+1-bit trial subtractor.
module div_datapath #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem
);

    // Shifted remainder needs WIDTH+1 bits; a set top bit of the trial means it went negative.
    logic [WIDTH:0] trial;

    assign trial = {rem, quo[WIDTH-1]} - {1'b0, divisor};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            quo <= '0;
            rem <= '0;
        end else if (load) begin
            quo <= dividend;
            rem <= '0;
        end else if (step) begin
            quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
            rem <= trial[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : trial[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/div_unit.sv
// DIV/DIVU sequencer for EX: accepts a request, runs WIDTH iterations, fixes signs,
// and returns registered quotient (lo) and remainder (hi). cancel aborts at any point.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DivCycles
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    div_state_e           state;
    logic [DivCntW-1:0]   cnt;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic                 sign_q;
    logic                 neg_q;
    logic                 neg_r;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rem;
    logic                 dp_load;
    logic                 dp_step;

    assign a_mag = (sign_q && a_q[WIDTH-1]) ? -a_q : a_q;
    assign b_mag = (sign_q && b_q[WIDTH-1]) ? -b_q : b_q;

    // b_q is held for the whole operation, so the divisor magnitude needs no extra register.
    assign dp_load = (state == DivPrep) && !cancel;
    assign dp_step = (state == DivCalc) && !cancel;

    div_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk      (clk),
        .resetn   (resetn),
        .load     (dp_load),
        .step     (dp_step),
        .dividend (a_mag),
        .divisor  (b_mag),
        .quo      (quo),
        .rem      (rem)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= DivIdle;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sign_q <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            lo     <= '0;
            hi     <= '0;
        end else begin
            done <= 1'b0;
            if (cancel) begin
                state <= DivIdle;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    DivIdle: begin
                        if (start) begin
                            a_q    <= a;
                            b_q    <= b;
                            sign_q <= sign;
                            busy   <= 1'b1;
                            state  <= DivPrep;
                        end
                    end
                    DivPrep: begin
                        neg_q <= sign_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                        neg_r <= sign_q & a_q[WIDTH-1];
                        cnt   <= '0;
                        if (b_q == '0) begin
                            hi    <= a_q;
                            lo    <= '1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DivDone;
                        end else begin
                            state <= DivCalc;
                        end
                    end
                    DivCalc: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == DivCntW'(WIDTH - 1)) begin
                            state <= DivFix;
                        end
                    end
                    DivFix: begin
                        lo    <= neg_q ? -quo : quo;
                        hi    <= neg_r ? -rem : rem;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DivDone;
                    end
                    DivDone: begin
                        state <= DivIdle;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= DivIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide-by-zero, cancel, reset.
module tb_div_unit;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] lo;
    logic [31:0] hi;

    int checks = 0;
    int errors = 0;

    div_unit #(
        .WIDTH (32)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .sign   (sign),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .lo     (lo),
        .hi     (hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Caller is in an IDLE cycle; that cycle is cycle 0. Leaves the bench in the next IDLE cycle.
    task automatic run_op(input string tag, input logic s, input logic [31:0] av,
                          input logic [31:0] bv, input int exp_done, input int exp_busy,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input logic hold);
        int done_cyc;
        int busy_cnt;
        int first_busy;
        done_cyc   = -1;
        busy_cnt   = 0;
        first_busy = -1;
        check({tag, "_busy_c0"}, {31'd0, busy}, 32'd0);
        start = 1'b1;
        sign  = s;
        a     = av;
        b     = bv;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            tick();
            if (busy) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = cyc;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        check({tag, "_done_cyc"}, done_cyc, exp_done);
        check({tag, "_busy_cnt"}, busy_cnt, exp_busy);
        check({tag, "_busy_first"}, first_busy, 1);
        check({tag, "_lo"}, lo, exp_lo);
        check({tag, "_hi"}, hi, exp_hi);
        if (!hold) start = 1'b0;
        tick();
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int seen_done;
        resetn = 1'b0;
        start  = 1'b0;
        sign   = 1'b0;
        a      = '0;
        b      = '0;
        cancel = 1'b0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_hi", hi, 32'd0);
        resetn = 1'b1;
        tick();

        run_op("divu_7_2", 1'b0, 32'd7, 32'd2, 35, 34, 32'd3, 32'd1, 1'b0);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 35, 34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1);
        // Back-to-back: start held through DONE, accepted from the following IDLE cycle.
        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 35, 34, 32'h8000_0000, 32'h0, 1'b0);
        run_op("divu_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 35, 34, 32'h0, 32'h8000_0000, 1'b0);
        run_op("divu_max", 1'b0, 32'hFFFF_FFFF, 32'h10, 35, 34, 32'h0FFF_FFFF, 32'hF, 1'b0);
        run_op("div0", 1'b1, 32'h1234_5678, 32'h0, 2, 1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0);

        // Cancel in cycle 10 of an operation.
        start = 1'b1;
        sign  = 1'b0;
        a     = 32'd1000;
        b     = 32'd3;
        for (int i = 0; i < 10; i++) tick();
        check("cxl_busy_c10", {31'd0, busy}, 32'd1);
        cancel = 1'b1;
        start  = 1'b0;
        tick();
        cancel = 1'b0;
        check("cxl_busy_c11", {31'd0, busy}, 32'd0);
        check("cxl_done_c11", {31'd0, done}, 32'd0);
        check("cxl_lo_keep", lo, 32'hFFFF_FFFF);
        check("cxl_hi_keep", hi, 32'h1234_5678);
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done || busy) seen_done = 1;
        end
        check("cxl_quiet", seen_done, 0);
        run_op("after_cxl", 1'b0, 32'd100, 32'd7, 35, 34, 32'd14, 32'd2, 1'b0);

        // Asynchronous reset in cycle 20 of an operation, start held across it.
        start = 1'b1;
        sign  = 1'b0;
        a     = 32'h0000_FFFF;
        b     = 32'h10;
        for (int i = 0; i < 20; i++) tick();
        check("rst20_busy_pre", {31'd0, busy}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("rst20_busy", {31'd0, busy}, 32'd0);
        check("rst20_done", {31'd0, done}, 32'd0);
        check("rst20_lo", lo, 32'd0);
        check("rst20_hi", hi, 32'd0);
        tick();
        resetn = 1'b1;
        run_op("after_rst", 1'b1, 32'd7, 32'hFFFF_FFFE, 35, 34, 32'hFFFF_FFFD, 32'd1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
